l15_anycore_reqencoder: RTL and testbench

L15_ANYCORE_REQENCODER -- requirements
Module: l15_anycorereqencoder

---
 rtl/l15_anycore_reqencoder.sv | 193 +++++++++++++++++++
 tb/tb_l15_anycore_reqencoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l15_anycore_reqencoder.sv
// AnyCore-to-L1.5 request encoder: one I-fill slot and one D (load/store) slot, round-robin issue.
// Optional ANYCORE_STORE_BYTESWAP_EN: store data is byte-reversed on the way out.
module l15_anycore_reqencoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        anycore_ic2mem_reqvalid,
   input  logic [39:0] anycore_ic2mem_reqaddr,
   input  logic        anycore_dc2mem_ldvalid,
   input  logic [39:0] anycore_dc2mem_ldaddr,
   input  logic        anycore_dc2mem_stvalid,
   input  logic [39:0] anycore_dc2mem_staddr,
   input  logic [63:0] anycore_dc2mem_stdata,
   input  logic [1:0]  anycore_dc2mem_stsize,
   input  logic        anycore_mem2ic_respvalid,
   input  logic        anycore_mem2dc_ldvalid,
   input  logic        anycore_mem2dc_stcomplete,
   output logic        transducer_l15_val,
   output logic [4:0]  transducer_l15_rqtype,
   output logic [39:0] transducer_l15_address,
   output logic [63:0] transducer_l15_data,
   output logic [2:0]  transducer_l15_size,
   input  logic        l15_transducer_header_ack,
   output logic        req_overflow
);

   localparam logic [4:0] LOAD_RQ  = 5'b00000;
   localparam logic [4:0] STORE_RQ = 5'b00001;
   localparam logic [4:0] IMISS_RQ = 5'b10000;

   typedef enum logic [1:0] {IDLE, ISSUE_I, ISSUE_D} state_e;

   state_e      state_q;
   logic        prio_i_q;
   logic        val_q;
   logic [4:0]  rqtype_q;
   logic [39:0] addr_q;
   logic [63:0] data_q;
   logic [2:0]  size_q;

   logic        i_vld_q, i_vld_d, i_iss_q, i_iss_d;
   logic [39:0] i_addr_q, i_addr_d;
   logic        d_vld_q, d_vld_d, d_iss_q, d_iss_d, d_st_q, d_st_d;
   logic [39:0] d_addr_q, d_addr_d;
   logic [63:0] d_data_q, d_data_d;
   logic [1:0]  d_stsize_q, d_stsize_d;
   logic        ovf_q, ovf_d;

   logic i_clr, d_clr, i_free, d_free, i_ack, d_ack, i_pend, d_pend;

   function automatic logic [63:0] store_data(input logic [63:0] d);
`ifdef ANYCORE_STORE_BYTESWAP_EN
      logic [63:0] s;
      for (int b = 0; b < 8; b++) s[8*b +: 8] = d[8*(7-b) +: 8];
      return s;
`else
      return d;
`endif
   endfunction

   always_comb begin
      i_clr  = i_iss_q & anycore_mem2ic_respvalid;
      d_clr  = d_iss_q & (d_st_q ? anycore_mem2dc_stcomplete : anycore_mem2dc_ldvalid);
      i_free = ~i_vld_q | i_clr;
      d_free = ~d_vld_q | d_clr;
      i_ack  = (state_q == ISSUE_I) & l15_transducer_header_ack;
      d_ack  = (state_q == ISSUE_D) & l15_transducer_header_ack;
      i_pend = i_vld_q & ~i_iss_q;
      d_pend = d_vld_q & ~d_iss_q;

      i_vld_d    = i_vld_q;
      i_iss_d    = i_iss_q;
      i_addr_d   = i_addr_q;
      d_vld_d    = d_vld_q;
      d_iss_d    = d_iss_q;
      d_st_d     = d_st_q;
      d_addr_d   = d_addr_q;
      d_data_d   = d_data_q;
      d_stsize_d = d_stsize_q;

      if (i_clr) begin
         i_vld_d = 1'b0;
         i_iss_d = 1'b0;
      end
      if (i_ack) i_iss_d = 1'b1;
      // A completion frees the slot in the same cycle a new pulse can refill it
      if (anycore_ic2mem_reqvalid && i_free) begin
         i_vld_d  = 1'b1;
         i_iss_d  = 1'b0;
         i_addr_d = anycore_ic2mem_reqaddr & ~40'h1F;
      end

      if (d_clr) begin
         d_vld_d = 1'b0;
         d_iss_d = 1'b0;
      end
      if (d_ack) d_iss_d = 1'b1;
      if (anycore_dc2mem_ldvalid && d_free) begin
         d_vld_d  = 1'b1;
         d_iss_d  = 1'b0;
         d_st_d   = 1'b0;
         d_addr_d = anycore_dc2mem_ldaddr & ~40'hF;
      end else if (anycore_dc2mem_stvalid && d_free) begin
         d_vld_d    = 1'b1;
         d_iss_d    = 1'b0;
         d_st_d     = 1'b1;
         d_addr_d   = anycore_dc2mem_staddr;
         d_data_d   = anycore_dc2mem_stdata;
         d_stsize_d = anycore_dc2mem_stsize;
      end

      // Simultaneous load+store loses the store, so it counts as an overflow too
      ovf_d = ovf_q
            | (anycore_ic2mem_reqvalid & ~i_free)
            | ((anycore_dc2mem_ldvalid | anycore_dc2mem_stvalid) & ~d_free)
            | (anycore_dc2mem_ldvalid & anycore_dc2mem_stvalid);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         i_vld_q <= 1'b0;
         i_iss_q <= 1'b0;
         d_vld_q <= 1'b0;
         d_iss_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         i_vld_q <= i_vld_d;
         i_iss_q <= i_iss_d;
         d_vld_q <= d_vld_d;
         d_iss_q <= d_iss_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      i_addr_q   <= i_addr_d;
      d_st_q     <= d_st_d;
      d_addr_q   <= d_addr_d;
      d_data_q   <= d_data_d;
      d_stsize_q <= d_stsize_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         prio_i_q <= 1'b1;
         val_q    <= 1'b0;
         rqtype_q <= 5'd0;
         addr_q   <= 40'd0;
         data_q   <= 64'd0;
         size_q   <= 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_pend && (!d_pend || prio_i_q)) begin
                  state_q  <= ISSUE_I;
                  prio_i_q <= 1'b0;
                  val_q    <= 1'b1;
                  rqtype_q <= IMISS_RQ;
                  addr_q   <= i_addr_q;
                  data_q   <= 64'd0;
                  size_q   <= 3'd0;
               end else if (d_pend) begin
                  state_q  <= ISSUE_D;
                  prio_i_q <= 1'b1;
                  val_q    <= 1'b1;
                  rqtype_q <= d_st_q ? STORE_RQ : LOAD_RQ;
                  addr_q   <= d_addr_q;
                  data_q   <= d_st_q ? store_data(d_data_q) : 64'd0;
                  size_q   <= d_st_q ? ({1'b0, d_stsize_q} + 3'd1) : 3'd0;
               end
            end
            ISSUE_I, ISSUE_D: begin
               if (l15_transducer_header_ack) begin
                  state_q <= IDLE;
                  val_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               val_q   <= 1'b0;
            end
         endcase
      end
   end

   assign transducer_l15_val     = val_q;
   assign transducer_l15_rqtype  = rqtype_q;
   assign transducer_l15_address = addr_q;
   assign transducer_l15_data    = data_q;
   assign transducer_l15_size    = size_q;
   assign req_overflow           = ovf_q;

endmodule

// File: tb/tb_l15_anycore_reqencoder.sv
// Directed bench for l15_anycore_reqencoder: vector table of single requests plus multi-cycle sequences.
module tb_l15_anycore_reqencoder;

   localparam logic [4:0] LOAD_RQ  = 5'b00000;
   localparam logic [4:0] STORE_RQ = 5'b00001;
   localparam logic [4:0] IMISS_RQ = 5'b10000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ic_v, ld_v, st_v, resp_i, resp_ld, resp_st, ack;
   logic [39:0] ic_a, ld_a, st_a;
   logic [63:0] st_d;
   logic [1:0]  st_s;
   logic        val, ovf;
   logic [4:0]  rqtype;
   logic [39:0] addr;
   logic [63:0] data;
   logic [2:0]  size;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   l15_anycore_reqencoder dut (
      .clk(clk), .rst_n(rst_n),
      .anycore_ic2mem_reqvalid(ic_v), .anycore_ic2mem_reqaddr(ic_a),
      .anycore_dc2mem_ldvalid(ld_v), .anycore_dc2mem_ldaddr(ld_a),
      .anycore_dc2mem_stvalid(st_v), .anycore_dc2mem_staddr(st_a),
      .anycore_dc2mem_stdata(st_d), .anycore_dc2mem_stsize(st_s),
      .anycore_mem2ic_respvalid(resp_i), .anycore_mem2dc_ldvalid(resp_ld),
      .anycore_mem2dc_stcomplete(resp_st),
      .transducer_l15_val(val), .transducer_l15_rqtype(rqtype),
      .transducer_l15_address(addr), .transducer_l15_data(data),
      .transducer_l15_size(size), .l15_transducer_header_ack(ack),
      .req_overflow(ovf)
   );

   typedef struct {
      int          kind;    // 0 ifill, 1 load, 2 store
      logic [39:0] a;
      logic [63:0] d;
      logic [1:0]  s;
      logic [4:0]  e_rq;
      logic [39:0] e_a;
      logic [63:0] e_d_raw;
      logic [63:0] e_d_swp;
      logic [2:0]  e_s;
   } vec_t;

   vec_t vt[8];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      ic_v = 0; ld_v = 0; st_v = 0; resp_i = 0; resp_ld = 0; resp_st = 0; ack = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [63:0] ed;
`ifdef ANYCORE_STORE_BYTESWAP_EN
      ed = v.e_d_swp;
`else
      ed = v.e_d_raw;
`endif
      case (v.kind)
         0: begin ic_v = 1; ic_a = v.a; end
         1: begin ld_v = 1; ld_a = v.a; end
         default: begin st_v = 1; st_a = v.a; st_d = v.d; st_s = v.s; end
      endcase
      step();
      clear_inputs();
      chk($sformatf("v%0d val_at_capture", idx), 64'(val), 64'd0);
      step();
      chk($sformatf("v%0d val", idx), 64'(val), 64'd1);
      chk($sformatf("v%0d rqtype", idx), 64'(rqtype), 64'(v.e_rq));
      chk($sformatf("v%0d addr", idx), 64'(addr), 64'(v.e_a));
      chk($sformatf("v%0d data", idx), data, ed);
      chk($sformatf("v%0d size", idx), 64'(size), 64'(v.e_s));
      ack = 1;
      step();
      ack = 0;
      chk($sformatf("v%0d val_after_ack", idx), 64'(val), 64'd0);
      case (v.kind)
         0: resp_i = 1;
         1: resp_ld = 1;
         default: resp_st = 1;
      endcase
      step();
      clear_inputs();
      chk($sformatf("v%0d overflow", idx), 64'(ovf), 64'd0);
   endtask

   initial begin
      vt[0] = '{0, 40'h00_8000_003F, 64'd0, 2'd0, IMISS_RQ, 40'h00_8000_0020, 64'd0, 64'd0, 3'b000};
      vt[1] = '{1, 40'h12_3456_789F, 64'd0, 2'd0, LOAD_RQ,  40'h12_3456_7890, 64'd0, 64'd0, 3'b000};
      vt[2] = '{2, 40'h00_0000_0010, 64'h0123456789ABCDEF, 2'd3, STORE_RQ, 40'h00_0000_0010,
                64'h0123456789ABCDEF, 64'hEFCDAB8967452301, 3'b100};
      vt[3] = '{2, 40'hFF_FFFF_FFFF, 64'hDEADBEEFCAFEF00D, 2'd0, STORE_RQ, 40'hFF_FFFF_FFFF,
                64'hDEADBEEFCAFEF00D, 64'h0DF0FECAEFBEADDE, 3'b001};
      vt[4] = '{2, 40'h00_0000_0007, 64'h11, 2'd1, STORE_RQ, 40'h00_0000_0007,
                64'h11, 64'h1100000000000000, 3'b010};
      vt[5] = '{2, 40'h00_0000_0104, 64'hA5, 2'd2, STORE_RQ, 40'h00_0000_0104,
                64'hA5, 64'hA500000000000000, 3'b011};
      vt[6] = '{0, 40'hFF_FFFF_FFFF, 64'd0, 2'd0, IMISS_RQ, 40'hFF_FFFF_FFE0, 64'd0, 64'd0, 3'b000};
      vt[7] = '{1, 40'h00_0000_001F, 64'd0, 2'd0, LOAD_RQ,  40'h00_0000_0010, 64'd0, 64'd0, 3'b000};

      ic_a = '0; ld_a = '0; st_a = '0; st_d = '0; st_s = '0;
      do_reset();
      step();
      chk("reset val", 64'(val), 64'd0);
      chk("reset ovf", 64'(ovf), 64'd0);
      chk("reset rqtype", 64'(rqtype), 64'd0);
      chk("reset addr", 64'(addr), 64'd0);
      chk("reset data", data, 64'd0);
      chk("reset size", 64'(size), 64'd0);

      for (int i = 0; i < 8; i++) run_vec(vt[i], i);

      // ifill and load together after reset: I first, load right after I's ack
      do_reset();
      ic_v = 1; ic_a = 40'h00_0000_1234; ld_v = 1; ld_a = 40'h00_0000_5678;
      step();
      clear_inputs();
      step();
      chk("rr first val", 64'(val), 64'd1);
      chk("rr first rqtype", 64'(rqtype), 64'(IMISS_RQ));
      chk("rr first addr", 64'(addr), 64'h00_0000_1220);
      ack = 1;
      step();
      ack = 0;
      chk("rr gap val", 64'(val), 64'd0);
      step();
      chk("rr second val", 64'(val), 64'd1);
      chk("rr second rqtype", 64'(rqtype), 64'(LOAD_RQ));
      chk("rr second addr", 64'(addr), 64'h00_0000_5670);
      ack = 1;
      step();
      ack = 0; resp_i = 1; resp_ld = 1;
      step();
      clear_inputs();
      chk("rr ovf", 64'(ovf), 64'd0);

      // Completion before issue is ignored; second load overflows and is dropped
      do_reset();
      ld_v = 1; ld_a = 40'h00_0000_0100;
      step();
      clear_inputs();
      step();
      chk("ovf L1 val", 64'(val), 64'd1);
      ack = 1; resp_ld = 1;
      step();
      clear_inputs();
      ld_v = 1; ld_a = 40'h00_0000_0200;
      step();
      clear_inputs();
      chk("ovf set", 64'(ovf), 64'd1);
      step();
      chk("ovf no reissue", 64'(val), 64'd0);
      resp_ld = 1;
      step();
      clear_inputs();
      chk("ovf held after clear", 64'(ovf), 64'd1);
      ld_v = 1; ld_a = 40'h00_0000_0300;
      step();
      clear_inputs();
      step();
      chk("ovf next load val", 64'(val), 64'd1);
      chk("ovf next load addr", 64'(addr), 64'h00_0000_0300);
      chk("ovf still held", 64'(ovf), 64'd1);
      ack = 1;
      step();
      clear_inputs();
      resp_ld = 1;
      step();
      clear_inputs();

      // Same-cycle completion and new capture of the D slot
      do_reset();
      ld_v = 1; ld_a = 40'h00_0000_0400;
      step();
      clear_inputs();
      step();
      ack = 1;
      step();
      clear_inputs();
      resp_ld = 1; ld_v = 1; ld_a = 40'h00_0000_0500;
      step();
      clear_inputs();
      chk("refill ovf", 64'(ovf), 64'd0);
      step();
      chk("refill val", 64'(val), 64'd1);
      chk("refill addr", 64'(addr), 64'h00_0000_0500);
      ack = 1;
      step();
      clear_inputs();
      resp_ld = 1;
      step();
      clear_inputs();

      // Load and store in the same cycle: load wins, overflow flagged
      do_reset();
      ld_v = 1; ld_a = 40'h00_0000_0600; st_v = 1; st_a = 40'h00_0000_0700; st_d = 64'h55; st_s = 2'd3;
      step();
      clear_inputs();
      chk("ldst ovf", 64'(ovf), 64'd1);
      step();
      chk("ldst rqtype", 64'(rqtype), 64'(LOAD_RQ));
      chk("ldst addr", 64'(addr), 64'h00_0000_0600);

      // Reset while awaiting ack abandons the request
      do_reset();
      ic_v = 1; ic_a = 40'h00_0000_0800;
      step();
      clear_inputs();
      step();
      chk("rst_mid val before", 64'(val), 64'd1);
      rst_n = 0; ack = 1;
      step();
      chk("rst_mid val", 64'(val), 64'd0);
      chk("rst_mid ovf", 64'(ovf), 64'd0);
      chk("rst_mid addr", 64'(addr), 64'd0);
      rst_n = 1; ack = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rst_mid no reissue %0d", k), 64'(val), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
